// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the byte-addressed data memory: port 0 fetches
// instructions (reads only), port 1 serves the LSU. One access in flight at a time.
module mem_port_arbiter #(
  parameter int MEM_DEPTH = 1024,
  parameter int PRIO_MODE = 0
) (
  input  logic        CLK,
  input  logic        RST_N,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [1:0]  req0_bsel,
  input  logic        req0_sext,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_rw,
  input  logic [31:0] req1_addr,
  input  logic [1:0]  req1_bsel,
  input  logic        req1_sext,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic [31:0] MEM_ADDR,
  output logic        MEM_CS,
  output logic        MEM_R_W,
  output logic [1:0]  MEM_BSEL,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        owner;       // 0 = port 0, 1 = port 1
  logic        last_grant;  // port granted most recently
  logic        rw_q;
  logic        sext_q;
  logic [1:0]  bsel_q;
  logic        rd_path;     // high during RESP of an in-range read
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        gnt0;
  logic        gnt1;
  logic [31:0] sel_addr;
  logic [1:0]  sel_bsel;
  logic        sel_rw;
  logic        sel_sext;
  logic [31:0] sel_wdata;
  logic        in_range;
  logic [31:0] ext_data;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] bsel,
                                         input logic sext);
    case (bsel)
      2'b00:   return {{24{sext & d[7]}},  d[7:0]};
      2'b01:   return {{16{sext & d[15]}}, d[15:0]};
      2'b10:   return {{8{sext & d[23]}},  d[23:0]};
      default: return d;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && RST_N) begin
      if (req0_valid && req1_valid) begin
        if (PRIO_MODE != 0 || !last_grant) gnt1 = 1'b1;
        else                               gnt0 = 1'b1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Port 0 is a pure fetch port: always a read, never carries write data.
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_bsel  = gnt1 ? req1_bsel  : req0_bsel;
  assign sel_rw    = gnt1 ? req1_rw    : 1'b1;
  assign sel_sext  = gnt1 ? req1_sext  : req0_sext;
  assign sel_wdata = gnt1 ? req1_wdata : 32'h0;

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign in_range = ({1'b0, sel_addr} + {31'b0, sel_bsel}) <= 33'(MEM_DEPTH - 1);

  // Memory read data is only valid during RESP; show it live then, hold it afterwards.
  assign ext_data   = extend(MEM_RDATA, bsel_q, sext_q);
  assign rsp0_rdata = (rsp0_valid && rd_path) ? ext_data : rdata0_q;
  assign rsp1_rdata = (rsp1_valid && rd_path) ? ext_data : rdata1_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rw_q       <= 1'b1;
      sext_q     <= 1'b0;
      bsel_q     <= 2'b00;
      rd_path    <= 1'b0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
      MEM_CS     <= 1'b0;
      MEM_R_W    <= 1'b1;
      MEM_ADDR   <= 32'h0;
      MEM_BSEL   <= 2'b00;
      MEM_WDATA  <= 32'h0;
    end else begin
      MEM_CS     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            owner      <= gnt1;
            last_grant <= gnt1;
            rw_q       <= sel_rw;
            sext_q     <= sel_sext;
            bsel_q     <= sel_bsel;
            if (in_range) begin
              state     <= ACCESS;
              MEM_CS    <= 1'b1;
              MEM_ADDR  <= sel_addr;
              MEM_R_W   <= sel_rw;
              MEM_BSEL  <= sel_bsel;
              MEM_WDATA <= sel_wdata;
            end else begin
              // Out of range: answer immediately, memory never sees the request.
              state   <= RESP;
              rd_path <= 1'b0;
              if (gnt1) begin
                rsp1_valid <= 1'b1;
                rsp1_err   <= 1'b1;
                rdata1_q   <= 32'h0;
              end else begin
                rsp0_valid <= 1'b1;
                rsp0_err   <= 1'b1;
                rdata0_q   <= 32'h0;
              end
            end
          end
        end
        ACCESS: begin
          state   <= RESP;
          rd_path <= rw_q;
          if (owner) begin
            rsp1_valid <= 1'b1;
            rsp1_err   <= 1'b0;
            if (!rw_q) rdata1_q <= 32'h0;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_err   <= 1'b0;
            if (!rw_q) rdata0_q <= 32'h0;
          end
        end
        RESP: begin
          state   <= IDLE;
          rd_path <= 1'b0;
          if (rd_path) begin
            if (owner) rdata1_q <= ext_data;
            else       rdata0_q <= ext_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressed data memory (one access per CLK, registered read data, BSEL-sized little-endian accesses) between two requesters: port 0 = instruction fetch (read-only), port 1 = load/store unit (read/write).
- Sits between the core front-end/LSU and the memory. Sequences one access at a time, range-checks it, and zero- or sign-extends narrow read data.
- The memory leaves the unread upper bits of narrow reads undefined; this block is the only place they are cleaned up.

Parameters:
- MEM_DEPTH, 1024: memory size in bytes; legal byte addresses are 0..MEM_DEPTH-1.
- PRIO_MODE, 0: 0 = round-robin between ports; 1 = fixed priority, port 1 always wins.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  synchronous active-low reset.
- req0_valid  input  1  port 0 read request.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_addr  input  32  port 0 byte address.
- req0_bsel  input  2  port 0 size code: 00=1 byte, 01=2, 10=3, 11=4.
- req0_sext  input  1  port 0: 1 = sign-extend, 0 = zero-extend.
- rsp0_valid  output  1  port 0 response pulse.
- rsp0_rdata  output  32  port 0 extended read data.
- rsp0_err  output  1  port 0 out-of-range error.
- req1_valid  input  1  port 1 request.
- req1_ready  output  1  port 1 request accepted this cycle.
- req1_rw  input  1  port 1: 1 = read, 0 = write.
- req1_addr  input  32  port 1 byte address.
- req1_bsel  input  2  port 1 size code.
- req1_sext  input  1  port 1 extension select.
- req1_wdata  input  32  port 1 write data, low bytes used.
- rsp1_valid  output  1  port 1 response pulse.
- rsp1_rdata  output  32  port 1 read data (0 for writes).
- rsp1_err  output  1  port 1 out-of-range error.
- MEM_ADDR  output  32  to memory ADDR.
- MEM_CS  output  1  to memory CS.
- MEM_R_W  output  1  to memory R_W (1 = read).
- MEM_BSEL  output  2  to memory BSEL.
- MEM_WDATA  output  32  to memory WR_MEM_DATA.
- MEM_RDATA  input  32  from memory RE_MEM_DATA.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is synchronous and active-low, sampled on the rising edge of CLK.
- Reset values:
  - FSM = IDLE.
  - MEM_CS=0, MEM_R_W=1, MEM_ADDR=0, MEM_BSEL=0, MEM_WDATA=0.
  - req*_ready=0, rsp*_valid=0, rsp*_rdata=0, rsp*_err=0.
  - Round-robin pointer = "port 1 last", so port 0 wins the first conflict.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Select the winner among valid ports and assert its reqN_ready combinationally. At most one ready is high at a time.
  - Port 0 is always treated as a read.
  - On the edge where valid&ready, latch owner, addr, bsel, rw, sext and wdata.
  - Range check: addr + bsel ≤ MEM_DEPTH-1, evaluated in 33-bit arithmetic so there is no wrap.
  - If in range -> ACCESS. If out of range -> RESP with err=1, and no memory cycle is issued.
- ACCESS: exactly one cycle. MEM_CS=1; MEM_ADDR, MEM_R_W, MEM_BSEL and MEM_WDATA driven from the latched fields. Then -> RESP.
- RESP:
  - rspN_valid=1 for exactly one cycle on the owner port only. Then -> IDLE.
  - Reads: rdata = MEM_RDATA with bytes above the size masked.
    - bsel 00: extend bit 7.
    - bsel 01: extend bit 15.
    - bsel 10: extend bit 23.
    - bsel 11: pass all 32 bits.
    - Extension fill = that bit if sext=1, else 0.
  - Writes: rdata=0, err=0.
  - Error responses: rdata=0, err=1.
- Outside RESP: rsp*_valid=0. rdata and err hold their last values.
- Latency: accept at cycle 0, MEM_CS high in cycle 1, rsp_valid in cycle 2, next accept possible in cycle 3. Error path: rsp_valid in cycle 1. Requesters must take the response when it is pulsed; there is no backpressure.
- Outside ACCESS: MEM_CS=0; other MEM_* outputs hold their latched values.
- Arbitration:
  - Only one valid port: that port wins.
  - Both valid, PRIO_MODE=0: the port not granted last wins. The pointer updates only on accept, including error accepts.
  - Both valid, PRIO_MODE=1: port 1 wins.
  - The losing port's request must remain valid and stable until it is accepted (requester obligation).
- Port 0 ignores write semantics: MEM_R_W is always 1 for port 0 accesses.
- Reset mid-operation:
  - RST_N low at any edge returns the block to IDLE with no response issued.
  - A write whose ACCESS cycle coincides with that edge may still be committed by the memory. Not an error.
- Requests arriving while not in IDLE are not accepted (ready=0).

Test Plan:
- Reset, then port1 writes: addr 0x10, bsel 11, wdata 0xDEADBEEF -> cycle1 MEM_CS=1, MEM_R_W=0, MEM_ADDR=0x10; cycle2 rsp1_valid=1, rsp1_rdata=0, rsp1_err=0.
- Port0 reads 0x10: bsel 00 sext 1 -> rsp0_rdata=0xFFFFFFEF; bsel 01 sext 0 -> 0x0000BEEF; bsel 10 sext 1 -> 0xFFADBEEF; bsel 11 -> 0xDEADBEEF.
- Both ports valid continuously, PRIO_MODE=0, from reset -> grants alternate 0,1,0,1, one accept every 3 cycles. With PRIO_MODE=1 -> port1 is granted every time while valid.
- Out-of-range requests:
  - Port1 read addr 0x3FE, bsel 11 -> no MEM_CS pulse; rsp1_valid in cycle1 with rsp1_err=1, rdata=0.
  - addr 0x3FD, bsel 10 -> normal access, err=0.
  - addr 0xFFFFFFFF, bsel 00 -> err=1.
- RST_N driven low during ACCESS of a port0 read -> no rsp0_valid; next cycle all outputs at reset values; a fresh request after reset completes normally.
